// File: rtl/rv32_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_decode_queue
//  Description : Decoded-instruction buffer between decode and execute.
//                Holds up to DEPTH decoded bundles behind valid/ready
//                handshakes on both sides, folds the illegal-instruction
//                check into the stored exception, tracks queued FENCEs for
//                the hazard unit and supports a global flush.
//
//  Ports
//    clk                      clock, all state on rising edge
//    reset                    synchronous, active-high
//    flush_in                 drop all queued entries and the current input
//    in_valid_in/in_ready_out producer handshake
//    in_decode_valid_in       control unit decoded a legal instruction
//    in_exception_in          upstream (fetch) exception flag
//    in_exception_cause_in    upstream exception cause
//    in_mem_fence_in          incoming bundle is a FENCE
//    in_payload_in            opaque decoded bundle
//    out_valid_out/out_ready_in consumer handshake
//    out_exception_out        head exception flag
//    out_exception_cause_out  head exception cause
//    out_mem_fence_out        head is a FENCE
//    out_payload_out          head bundle
//    count_out                number of occupied entries
//    fence_pending_out        some queued entry is a FENCE
//
//  Revision    : 1.0  initial release
// ============================================================================
module rv32_decode_queue #(
    parameter int                 PAYLOAD_W     = 128,
    parameter int                 DEPTH         = 4,
    parameter int                 CAUSE_W       = 4,
    parameter logic [CAUSE_W-1:0] ILLEGAL_CAUSE = CAUSE_W'(2)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_in,
    // producer side
    input  logic                         in_valid_in,
    output logic                         in_ready_out,
    input  logic                         in_decode_valid_in,
    input  logic                         in_exception_in,
    input  logic [CAUSE_W-1:0]           in_exception_cause_in,
    input  logic                         in_mem_fence_in,
    input  logic [PAYLOAD_W-1:0]         in_payload_in,
    // consumer side
    output logic                         out_valid_out,
    input  logic                         out_ready_in,
    output logic                         out_exception_out,
    output logic [CAUSE_W-1:0]           out_exception_cause_out,
    output logic                         out_mem_fence_out,
    output logic [PAYLOAD_W-1:0]         out_payload_out,
    // status
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         fence_pending_out
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // Pointer wrap relies on DEPTH being a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rv32_decode_queue: DEPTH must be a power of two >= 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_fence_cnt;

    // Storage is deliberately not reset; occupancy is tracked by r_count.
    logic [PAYLOAD_W-1:0] r_payload_mem [DEPTH];
    logic [CAUSE_W-1:0]   r_cause_mem   [DEPTH];
    logic [DEPTH-1:0]     r_exc_mem;
    logic [DEPTH-1:0]     r_fence_mem;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;
    logic w_fence_push;
    logic w_fence_pop;

    // Both flags come from registered state only, so there is no
    // combinational path from out_ready_in to in_ready_out. When full,
    // a same-cycle dequeue does not open a slot for the producer.
    assign w_in_ready   = (r_count != c_FULL);
    assign w_out_valid  = (r_count != '0);

    // Flush voids both handshakes: the consumer is being flushed as well.
    assign w_push       = in_valid_in & w_in_ready & ~flush_in;
    assign w_pop        = w_out_valid & out_ready_in & ~flush_in;

    assign w_fence_push = w_push & in_mem_fence_in;
    assign w_fence_pop  = w_pop & r_fence_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Exception folding: an instruction that neither decoded legally nor
    // carried an upstream exception is stored as an illegal instruction.
    // An upstream exception always wins because it happened earlier.
    // ------------------------------------------------------------------
    logic               w_store_exc;
    logic [CAUSE_W-1:0] w_store_cause;

    always_comb begin
        w_store_exc   = in_exception_in;
        w_store_cause = in_exception_cause_in;
        if (!in_exception_in && !in_decode_valid_in) begin
            w_store_exc   = 1'b1;
            w_store_cause = ILLEGAL_CAUSE;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and fence counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fence_cnt <= '0;
        end else if (flush_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fence_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            case ({w_fence_push, w_fence_pop})
                2'b10:   r_fence_cnt <= r_fence_cnt + c_CNT_ONE;
                2'b01:   r_fence_cnt <= r_fence_cnt - c_CNT_ONE;
                default: r_fence_cnt <= r_fence_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_payload_mem[r_wr_ptr] <= in_payload_in;
            r_cause_mem[r_wr_ptr]   <= w_store_cause;
            r_exc_mem[r_wr_ptr]     <= w_store_exc;
            r_fence_mem[r_wr_ptr]   <= in_mem_fence_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head is read straight from storage (first-word
    // fall-through) and forced to zero while the queue is empty so stale
    // storage contents never leak to execute.
    // ------------------------------------------------------------------
    assign in_ready_out            = w_in_ready;
    assign out_valid_out           = w_out_valid;
    assign out_payload_out         = w_out_valid ? r_payload_mem[r_rd_ptr] : '0;
    assign out_exception_cause_out = w_out_valid ? r_cause_mem[r_rd_ptr]   : '0;
    assign out_exception_out       = w_out_valid & r_exc_mem[r_rd_ptr];
    assign out_mem_fence_out       = w_out_valid & r_fence_mem[r_rd_ptr];
    assign count_out               = r_count;
    assign fence_pending_out       = (r_fence_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_decode_queue
//  Description : Self-checking bench for rv32_decode_queue (DEPTH=4).
//                Table-driven vectors plus hand-written multi-cycle
//                sequences; a scoreboard queue holds expected head entries.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32_decode_queue;

    localparam int PAYLOAD_W = 128;
    localparam int DEPTH     = 4;
    localparam int CAUSE_W   = 4;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 flush_in = 1'b0;
    logic                 in_valid_in = 1'b0;
    logic                 in_ready_out;
    logic                 in_decode_valid_in = 1'b0;
    logic                 in_exception_in = 1'b0;
    logic [CAUSE_W-1:0]   in_exception_cause_in = '0;
    logic                 in_mem_fence_in = 1'b0;
    logic [PAYLOAD_W-1:0] in_payload_in = '0;
    logic                 out_valid_out;
    logic                 out_ready_in = 1'b0;
    logic                 out_exception_out;
    logic [CAUSE_W-1:0]   out_exception_cause_out;
    logic                 out_mem_fence_out;
    logic [PAYLOAD_W-1:0] out_payload_out;
    logic [CNT_W-1:0]     count_out;
    logic                 fence_pending_out;

    rv32_decode_queue #(
        .PAYLOAD_W     (PAYLOAD_W),
        .DEPTH         (DEPTH),
        .CAUSE_W       (CAUSE_W),
        .ILLEGAL_CAUSE (4'd2)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .flush_in                (flush_in),
        .in_valid_in             (in_valid_in),
        .in_ready_out            (in_ready_out),
        .in_decode_valid_in      (in_decode_valid_in),
        .in_exception_in         (in_exception_in),
        .in_exception_cause_in   (in_exception_cause_in),
        .in_mem_fence_in         (in_mem_fence_in),
        .in_payload_in           (in_payload_in),
        .out_valid_out           (out_valid_out),
        .out_ready_in            (out_ready_in),
        .out_exception_out       (out_exception_out),
        .out_exception_cause_out (out_exception_cause_out),
        .out_mem_fence_out       (out_mem_fence_out),
        .out_payload_out         (out_payload_out),
        .count_out               (count_out),
        .fence_pending_out       (fence_pending_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                 exc;
        logic [CAUSE_W-1:0]   cause;
        logic                 fence;
        logic [PAYLOAD_W-1:0] payload;
    } ent_t;

    typedef struct {
        logic                 dv;
        logic                 exc;
        logic [CAUSE_W-1:0]   cause;
        logic                 fence;
        logic [PAYLOAD_W-1:0] payload;
        logic                 exp_exc;
        logic [CAUSE_W-1:0]   exp_cause;
    } vec_t;

    ent_t sb[$];
    vec_t tbl[8];
    int   n_pass   = 0;
    int   n_checks = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic ent_t model(input logic dv, input logic exc, input logic [CAUSE_W-1:0] cause,
                                   input logic fence, input logic [PAYLOAD_W-1:0] p);
        ent_t e;
        e.exc     = exc | ~dv;
        e.cause   = (!exc && !dv) ? 4'd2 : cause;
        e.fence   = fence;
        e.payload = p;
        return e;
    endfunction

    // Scoreboard monitor, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin : mon
        int sz;
        bit fp;
        if (mon_en) begin
            sz = sb.size();
            fp = 1'b0;
            foreach (sb[k]) if (sb[k].fence) fp = 1'b1;
            check("status{count,fence_pend,in_ready,out_valid}",
                  {count_out, fence_pending_out, in_ready_out, out_valid_out},
                  {CNT_W'(sz), fp, (sz != DEPTH), (sz != 0)});
            if (sz == 0)
                check("empty_head_zero",
                      {out_exception_out, out_exception_cause_out, out_mem_fence_out, out_payload_out}, '0);
            if (reset || flush_in) begin
                sb.delete();
            end else begin
                if ((sz != 0) && out_ready_in) begin
                    check("head_entry",
                          {out_exception_out, out_exception_cause_out, out_mem_fence_out, out_payload_out},
                          sb[0]);
                    void'(sb.pop_front());
                end
                if (in_valid_in && (sz != DEPTH))
                    sb.push_back(model(in_decode_valid_in, in_exception_in, in_exception_cause_in,
                                       in_mem_fence_in, in_payload_in));
            end
        end
    end

    task automatic drive_vec(input vec_t v);
        in_valid_in           = 1'b1;
        in_decode_valid_in    = v.dv;
        in_exception_in       = v.exc;
        in_exception_cause_in = v.cause;
        in_mem_fence_in       = v.fence;
        in_payload_in         = v.payload;
    endtask

    task automatic idle_in();
        in_valid_in           = 1'b0;
        in_decode_valid_in    = 1'b0;
        in_exception_in       = 1'b0;
        in_exception_cause_in = '0;
        in_mem_fence_in       = 1'b0;
        in_payload_in         = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        vec_t rv;
        bit   acc;
        int   guard;

        //            dv    exc   cause fence payload                                  exp_exc exp_cause
        tbl[0] = '{1'b1, 1'b0, 4'd0, 1'b0, 128'hAAAA_0000_1111_2222_3333_4444_5555_0001, 1'b0, 4'd0};
        tbl[1] = '{1'b0, 1'b0, 4'd0, 1'b0, 128'hBBBB_0000_1111_2222_3333_4444_5555_0002, 1'b1, 4'd2};
        tbl[2] = '{1'b0, 1'b1, 4'd1, 1'b0, 128'hCCCC_0000_1111_2222_3333_4444_5555_0003, 1'b1, 4'd1};
        tbl[3] = '{1'b1, 1'b1, 4'd5, 1'b0, 128'hDDDD_0000_1111_2222_3333_4444_5555_0004, 1'b1, 4'd5};
        tbl[4] = '{1'b1, 1'b0, 4'd0, 1'b1, 128'hF0F0_F0F0_0000_0000_0000_0000_0000_0005, 1'b0, 4'd0};
        tbl[5] = '{1'b1, 1'b0, 4'd0, 1'b0, 128'h0123_4567_89AB_CDEF_0000_0000_0000_0006, 1'b0, 4'd0};
        tbl[6] = '{1'b1, 1'b0, 4'd0, 1'b0, 128'hFEDC_BA98_7654_3210_0000_0000_0000_0007, 1'b0, 4'd0};
        tbl[7] = '{1'b1, 1'b0, 4'd0, 1'b0, 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_0008, 1'b0, 4'd0};

        // ---- reset then idle
        cyc();
        cyc();
        reset  = 1'b0;
        mon_en = 1'b1;
        check("rst_in_ready",  in_ready_out, 1);
        check("rst_out_valid", out_valid_out, 0);
        check("rst_count",     count_out, 0);
        check("rst_payload",   out_payload_out, 0);
        check("rst_fence",     fence_pending_out, 0);

        // ---- fill A..D with consumer stalled, E held off, then drain
        out_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_vec(tbl[i]);
            cyc();
            check($sformatf("fill_count%0d", i), count_out, i + 1);
        end
        check("full_in_ready", in_ready_out, 0);
        drive_vec(tbl[7]);
        cyc();
        cyc();
        check("full_hold_count", count_out, 4);
        idle_in();
        out_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_head_exc%0d", i),
                  {out_exception_out, out_exception_cause_out, out_payload_out},
                  {tbl[i].exp_exc, tbl[i].exp_cause, tbl[i].payload});
            cyc();
            check($sformatf("drain_count%0d", i), count_out, 3 - i);
        end
        out_ready_in = 1'b0;

        // ---- fence tracking: fence then two ALU ops
        drive_vec(tbl[4]);
        cyc();
        check("fence_pend_after_enq", fence_pending_out, 1);
        drive_vec(tbl[5]);
        cyc();
        drive_vec(tbl[6]);
        cyc();
        idle_in();
        check("fence_pend_queued", fence_pending_out, 1);
        out_ready_in = 1'b1;
        check("fence_head", out_mem_fence_out, 1);
        cyc();
        out_ready_in = 1'b0;
        check("fence_pend_after_deq", fence_pending_out, 0);
        check("fence_count_after_deq", count_out, 2);
        out_ready_in = 1'b1;
        cyc();
        cyc();
        out_ready_in = 1'b0;
        check("fence_drained", count_out, 0);

        // ---- flush with both handshakes active
        drive_vec(tbl[4]);
        cyc();
        drive_vec(tbl[5]);
        cyc();
        drive_vec(tbl[6]);
        cyc();
        drive_vec(tbl[7]);
        flush_in     = 1'b1;
        out_ready_in = 1'b1;
        check("pre_flush_count", count_out, 3);
        cyc();
        flush_in     = 1'b0;
        out_ready_in = 1'b0;
        idle_in();
        check("flush_count", count_out, 0);
        check("flush_fence", fence_pending_out, 0);
        check("flush_out_valid", out_valid_out, 0);
        drive_vec(tbl[0]);
        check("no_bypass", out_valid_out, 0);
        cyc();
        idle_in();
        check("post_flush_head", {out_valid_out, out_payload_out}, {1'b1, tbl[0].payload});
        out_ready_in = 1'b1;
        cyc();
        out_ready_in = 1'b0;

        // ---- reset mid-stream
        drive_vec(tbl[5]);
        cyc();
        drive_vec(tbl[4]);
        cyc();
        idle_in();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_count", count_out, 0);
        check("midrst_fence", fence_pending_out, 0);
        drive_vec(tbl[3]);
        cyc();
        idle_in();
        check("midrst_head", {out_exception_out, out_exception_cause_out, out_payload_out},
              {1'b1, 4'd5, tbl[3].payload});
        out_ready_in = 1'b1;
        cyc();
        out_ready_in = 1'b0;

        // ---- wrap: 2*DEPTH+3 enqueues with random consumer stalls
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            rv.dv      = 1'($urandom_range(0, 1));
            rv.exc     = 1'($urandom_range(0, 1));
            rv.cause   = 4'($urandom_range(0, 15));
            rv.fence   = 1'($urandom_range(0, 1));
            rv.payload = {$urandom, $urandom, $urandom, $urandom};
            drive_vec(rv);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 50) begin
                out_ready_in = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = in_ready_out;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) check("enq_timeout", acc, 1);
        end
        idle_in();
        out_ready_in = 1'b1;
        guard = 0;
        while (count_out != 0 && guard < 20) begin
            cyc();
            guard++;
        end
        check("wrap_drained", count_out, 0);
        cyc();
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
